// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the single-issue RISC-V core front end.
//   fetch_state_t : fetch controller states (REQ, WAIT, FULL, DROP)
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) loaded into Instr on reset
//   OP_*          : major opcode values seen in Instr[6:0]
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      FULL = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the fetch stage's instruction-memory handshake, the decode-side
// handshake and the branch redirect input.
//   master : fetch stage view (drives ImemReq/ImemAddr and the decode outputs)
//   slave  : environment view (memory, decode and execute redirect)
// Signals:
//   ImemReq, ImemAddr[ADDR_W], ImemValid, ImemData[32]      memory side
//   InstrValid, InstrReady, Instr[32], Op[7], Funct3[3],
//   Funct7[7], PcOut[ADDR_W]                                decode side
//   Redirect, BranchTarget[ADDR_W]                          execute redirect
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int ADDR_W = 8
);
   logic              ImemReq;
   logic [ADDR_W-1:0] ImemAddr;
   logic              ImemValid;
   logic [31:0]       ImemData;

   logic              InstrValid;
   logic              InstrReady;
   logic [31:0]       Instr;
   logic [6:0]        Op;
   logic [2:0]        Funct3;
   logic [6:0]        Funct7;
   logic [ADDR_W-1:0] PcOut;

   logic              Redirect;
   logic [ADDR_W-1:0] BranchTarget;

   modport master (
      output ImemReq, ImemAddr, InstrValid, Instr, Op, Funct3, Funct7, PcOut,
      input  ImemValid, ImemData, InstrReady, Redirect, BranchTarget
   );

   modport slave (
      input  ImemReq, ImemAddr, InstrValid, Instr, Op, Funct3, Funct7, PcOut,
      output ImemValid, ImemData, InstrReady, Redirect, BranchTarget
   );
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter with reset value, +4 increment and redirect mux.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   inc         : advance PC by 4 (wraps modulo 2^ADDR_W)
//   redirect    : load target with bits [1:0] cleared; wins over inc
//   target      : redirect address
//   pc          : current program counter
// -----------------------------------------------------------------------------
module pc_reg #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= {target[ADDR_W-1:2], 2'b00};
      end else if (inc) begin
         pc <= pc + ADDR_W'(4);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: holds the PC, requests words from instruction memory, latches
// the returned word into the instruction register and offers it to decode.
// A taken-branch redirect reloads the PC and discards wrong-path responses.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : instr_fetch_if.master (memory, decode and redirect signals)
//   StallCnt   : cycles with InstrValid & ~InstrReady (FETCH_PERF_CNT_EN only)
//   FlushCnt   : cycles with Redirect asserted        (FETCH_PERF_CNT_EN only)
// Optional feature macro: FETCH_PERF_CNT_EN adds the saturating counters.
// -----------------------------------------------------------------------------
module instr_fetch
   import core_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   instr_fetch_if.master   bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]     StallCnt,
   output logic [15:0]     FlushCnt
`endif
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc;
   logic              imem_req;
   logic              instr_valid;
   logic              capture;
   logic              accept;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (accept),
      .redirect (bus.Redirect),
      .target   (bus.BranchTarget),
      .pc       (pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= REQ;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         REQ, WAIT: begin
            if (bus.Redirect) begin
               // A response arriving with the redirect is simply dropped;
               // otherwise one is still in flight and must be absorbed.
               state_nxt = bus.ImemValid ? REQ : DROP;
            end else if (bus.ImemValid) begin
               state_nxt = FULL;
            end else begin
               state_nxt = WAIT;
            end
         end
         FULL: begin
            if (bus.Redirect || bus.InstrReady) begin
               state_nxt = REQ;
            end
         end
         DROP: begin
            // A redirect here only moves the PC; the stale response still
            // has to be swallowed, and it may arrive in this very cycle.
            if (bus.ImemValid) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

   always_comb begin
      // Held low throughout reset so the request appears only after release.
      imem_req    = rst_n && (state == REQ);
      instr_valid = (state == FULL);
      capture     = ((state == REQ) || (state == WAIT)) && bus.ImemValid && !bus.Redirect;
      accept      = instr_valid && bus.InstrReady;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
      end else if (capture) begin
         instr_q <= bus.ImemData;
      end
   end

   assign bus.ImemReq    = imem_req;
   assign bus.ImemAddr   = pc;
   assign bus.InstrValid = instr_valid;
   assign bus.Instr      = instr_q;
   assign bus.Op         = instr_q[6:0];
   assign bus.Funct3     = instr_q[14:12];
   assign bus.Funct7     = instr_q[31:25];
   // PC only moves on accept or redirect, both of which also empty Instr.
   assign bus.PcOut      = pc;

`ifdef FETCH_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (instr_valid && !bus.InstrReady) begin
            StallCnt <= sat_inc(StallCnt);
         end
         if (bus.Redirect) begin
            FlushCnt <= sat_inc(FlushCnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed steps followed by randomized traffic for instr_fetch. A
// transaction-level reference tracks which PC decode must see next and the
// memory image that word comes from; a memory model answers each request
// after a fixed or random latency. Optional macro FETCH_PERF_CNT_EN also
// checks StallCnt/FlushCnt.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
   import core_pkg::*;

   logic clk;
   logic rst_n;

   instr_fetch_if #(.ADDR_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] StallCnt;
   logic [15:0] FlushCnt;
`endif

   instr_fetch #(
      .ADDR_W   (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .StallCnt (StallCnt),
      .FlushCnt (FlushCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference state
   logic [31:0] mem [64];
   logic [7:0]  m_pc;
   bit          pend;
   int          pcnt;
   logic [7:0]  paddr;
   int          fix_lat;
   bit          hold;
   logic [31:0] hold_instr;
   logic [7:0]  hold_pc;
   int          n_cmp;
   int          n_err;
   int          n_acc;
   int          m_stall;
   int          m_flush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic deliver(input logic [7:0] addr);
      bus.ImemValid = 1'b1;
      bus.ImemData  = mem[addr[7:2]];
   endtask

   // One clock cycle: check outputs, drive this cycle's inputs, advance the
   // reference for the coming edge, then move to the next falling edge.
   task automatic step(input bit rdy, input bit redir, input logic [7:0] tgt);
      int          lat;
      logic [31:0] w;
      if (hold) begin
         chk("hold_valid", {31'd0, bus.InstrValid}, 32'd1);
         chk("hold_instr", bus.Instr, hold_instr);
         chk("hold_pc", {24'd0, bus.PcOut}, {24'd0, hold_pc});
      end
      if (bus.InstrValid === 1'b1) begin
         w = mem[m_pc[7:2]];
         chk("pc_out", {24'd0, bus.PcOut}, {24'd0, m_pc});
         chk("instr", bus.Instr, w);
         chk("op", {25'd0, bus.Op}, {25'd0, w[6:0]});
         chk("funct3", {29'd0, bus.Funct3}, {29'd0, w[14:12]});
         chk("funct7", {25'd0, bus.Funct7}, {25'd0, w[31:25]});
         chk("req_while_full", {31'd0, bus.ImemReq}, 32'd0);
      end
      bus.InstrReady   = rdy;
      bus.Redirect     = redir;
      bus.BranchTarget = tgt;
      bus.ImemValid    = 1'b0;
      bus.ImemData     = 32'h0;
      if (bus.ImemReq === 1'b1) begin
         chk("imem_addr", {24'd0, bus.ImemAddr}, {24'd0, m_pc});
         lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
         if (lat == 0) begin
            deliver(bus.ImemAddr);
         end else begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = bus.ImemAddr;
         end
      end else if (pend) begin
         pcnt--;
         if (pcnt == 0) begin
            pend = 1'b0;
            deliver(paddr);
         end
      end
      if (bus.InstrValid === 1'b1 && !rdy) m_stall++;
      if (redir) m_flush++;
      if (bus.InstrValid === 1'b1 && rdy) n_acc++;
      hold       = (bus.InstrValid === 1'b1) && !rdy && !redir;
      hold_instr = bus.Instr;
      hold_pc    = bus.PcOut;
      if (redir) begin
         m_pc = tgt & 8'hFC;
      end else if (bus.InstrValid === 1'b1 && rdy) begin
         m_pc = m_pc + 8'd4;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_pc    = 8'h00;
      pend    = 1'b0;
      pcnt    = 0;
      hold    = 1'b0;
      m_stall = 0;
      m_flush = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  ops [5];
      logic [31:0] w;
`ifdef FETCH_PERF_CNT_EN
      logic [15:0] stall0;
`endif
      n_cmp = 0; n_err = 0; n_acc = 0;
      fix_lat = 0;
      paddr = 8'h00;
      hold_instr = 32'h0;
      hold_pc = 8'h00;
      model_reset();

      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;
      // Distinct words: index in bits [30:25] so wrong-path data is detectable.
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 4)];
         w[30:25] = i[5:0];
         mem[i] = w;
      end
      mem[0] = 32'h00500093;
      mem[1] = 32'h00A00113;

      bus.ImemValid = 1'b0; bus.ImemData = 32'h0; bus.InstrReady = 1'b0;
      bus.Redirect = 1'b0; bus.BranchTarget = 8'h00;
      rst_n = 1'b0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {31'd0, bus.ImemReq}, 32'd0);
      chk("rst_valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("rst_instr", bus.Instr, NOP_INSTR);
      chk("rst_pc", {24'd0, bus.PcOut}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("req_after_rst", {31'd0, bus.ImemReq}, 32'd1);

      // zero-wait memory, two-instruction program
      fix_lat = 0;
      step(1'b1, 1'b0, 8'h00);
      chk("p0_valid", {31'd0, bus.InstrValid}, 32'd1);
      chk("p0_instr", bus.Instr, 32'h00500093);
      chk("p0_op", {25'd0, bus.Op}, {25'd0, OP_I});
      chk("p0_funct3", {29'd0, bus.Funct3}, 32'd0);
      chk("p0_pc", {24'd0, bus.PcOut}, 32'h00);
      step(1'b1, 1'b0, 8'h00);
      chk("p1_addr", {24'd0, bus.ImemAddr}, 32'h04);
      step(1'b1, 1'b0, 8'h00);
      chk("p1_instr", bus.Instr, 32'h00A00113);
      chk("p1_pc", {24'd0, bus.PcOut}, 32'h04);
      step(1'b1, 1'b0, 8'h00);

      // two-cycle wait memory: single request pulse, valid one cycle after data
      fix_lat = 2;
      step(1'b1, 1'b0, 8'h00);
      chk("lat_req_pulse1", {31'd0, bus.ImemReq}, 32'd0);
      chk("lat_valid1", {31'd0, bus.InstrValid}, 32'd0);
      step(1'b1, 1'b0, 8'h00);
      chk("lat_req_pulse2", {31'd0, bus.ImemReq}, 32'd0);
      chk("lat_valid2", {31'd0, bus.InstrValid}, 32'd0);
      step(1'b0, 1'b0, 8'h00);
      chk("lat_valid3", {31'd0, bus.InstrValid}, 32'd1);
      chk("lat_pc", {24'd0, bus.PcOut}, 32'h08);

      // decode stalls for 5 cycles
`ifdef FETCH_PERF_CNT_EN
      stall0 = StallCnt;
`endif
      repeat (5) step(1'b0, 1'b0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt_5", {16'd0, StallCnt - stall0}, 32'd5);
`endif
      step(1'b1, 1'b0, 8'h00);

      // redirect while waiting: in-flight word discarded, refetch at 0x20
      fix_lat = 3;
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h23);
      chk("drop_valid1", {31'd0, bus.InstrValid}, 32'd0);
      step(1'b1, 1'b0, 8'h00);
      chk("drop_valid2", {31'd0, bus.InstrValid}, 32'd0);
      step(1'b1, 1'b0, 8'h00);
      chk("drop_valid3", {31'd0, bus.InstrValid}, 32'd0);
      chk("redir_req", {31'd0, bus.ImemReq}, 32'd1);
      chk("redir_addr", {24'd0, bus.ImemAddr}, 32'h20);
      fix_lat = 0;
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);

      // PC wrap from 0xFC
      step(1'b1, 1'b1, 8'hFE);
      chk("wrap_start", {24'd0, bus.ImemAddr}, 32'hFC);
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      chk("wrap_req", {31'd0, bus.ImemReq}, 32'd1);
      chk("wrap_addr", {24'd0, bus.ImemAddr}, 32'h00);

      // reset while FULL at PC 0x40
      step(1'b1, 1'b1, 8'h40);
      step(1'b0, 1'b0, 8'h00);
      chk("full40_valid", {31'd0, bus.InstrValid}, 32'd1);
      chk("full40_pc", {24'd0, bus.PcOut}, 32'h40);
      bus.ImemValid = 1'b0; bus.Redirect = 1'b0; bus.InstrReady = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("mid_rst_instr", bus.Instr, NOP_INSTR);
      chk("mid_rst_req", {31'd0, bus.ImemReq}, 32'd0);
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_refetch", {24'd0, bus.ImemAddr}, 32'h00);
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);

      // randomized traffic
      fix_lat = -1;
      for (int c = 0; c < 500; c++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 8'($urandom));
      end
      chk("progress", {31'd0, (n_acc >= 20)}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", {16'd0, StallCnt}, m_stall);
      chk("flush_cnt", {16'd0, FlushCnt}, m_flush);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
